// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two dmem requesters, the arbiter and the data memory.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface dmem_arbiter_if;
  // port 0: CPU load/store path
  logic        req0;
  logic        we0;
  logic [31:0] adr0;
  logic [31:0] wd0;
  logic        gnt0;
  logic [31:0] rd0;
  logic        rvalid0;

  // port 1: DMA / debug loader
  logic        req1;
  logic        we1;
  logic [31:0] adr1;
  logic [31:0] wd1;
  logic        lock1;
  logic        gnt1;
  logic [31:0] rd1;
  logic        rvalid1;

  // data memory side
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req0, we0, adr0, wd0,
    input  req1, we1, adr1, wd1, lock1,
    input  mem_rd,
    output gnt0, rd0, rvalid0,
    output gnt1, rd1, rvalid1,
    output mem_we, mem_adr, mem_wd
  );

  modport master (
    output req0, we0, adr0, wd0,
    output req1, we1, adr1, wd1, lock1,
    output mem_rd,
    input  gnt0, rd0, rvalid0,
    input  gnt1, rd1, rvalid1,
    input  mem_we, mem_adr, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: round-robin with a bounded port 1 lock and a
// port 0 starvation guard; read data comes back registered one cycle after grant.
module dmem_arbiter #(
  parameter int MAX_LOCK     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int LW = $clog2(MAX_LOCK) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  // last_q = 1 means port 1 held the most recent grant
  logic          last_q,         last_d;
  logic          owner_locked_q, owner_locked_d;
  logic [LW-1:0] lockcnt_q,      lockcnt_d;
  logic [SW-1:0] starvecnt_q,    starvecnt_d;
  logic [31:0]   rd0_q,          rd0_d;
  logic [31:0]   rd1_q,          rd1_d;
  logic          rvalid0_q,      rvalid0_d;
  logic          rvalid1_q,      rvalid1_d;

  logic grant0;
  logic grant1;
  logic starve_force;
  logic lock_hold;

  assign starve_force = bus.req0 && (starvecnt_q == SW'(STARVE_LIMIT));
  // With port 0 idle the lock is unbounded; the bound only protects port 0.
  assign lock_hold    = owner_locked_q && bus.req1 &&
                        ((lockcnt_q < LW'(MAX_LOCK)) || !bus.req0);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (starve_force) begin
      grant0 = 1'b1;
    end else if (lock_hold) begin
      grant1 = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      if (last_q) grant0 = 1'b1;
      else        grant1 = 1'b1;
    end else if (bus.req0) begin
      grant0 = 1'b1;
    end else if (bus.req1) begin
      grant1 = 1'b1;
    end
  end

  // Memory mux; writes are suppressed while reset is asserted.
  always_comb begin
    bus.mem_we  = 1'b0;
    bus.mem_adr = '0;
    bus.mem_wd  = '0;
    if (grant0) begin
      bus.mem_we  = bus.we0 && !reset;
      bus.mem_adr = bus.adr0;
      bus.mem_wd  = bus.wd0;
    end else if (grant1) begin
      bus.mem_we  = bus.we1 && !reset;
      bus.mem_adr = bus.adr1;
      bus.mem_wd  = bus.wd1;
    end
  end

  always_comb begin
    last_d         = last_q;
    owner_locked_d = grant1 && bus.lock1;
    lockcnt_d      = lockcnt_q;
    starvecnt_d    = starvecnt_q;
    rvalid0_d      = grant0 && !bus.we0;
    rvalid1_d      = grant1 && !bus.we1;
    rd0_d          = rd0_q;
    rd1_d          = rd1_q;

    if (grant0)      last_d = 1'b0;
    else if (grant1) last_d = 1'b1;

    if (!grant1 || !bus.lock1) begin
      lockcnt_d = '0;
    end else if (bus.req0 && (lockcnt_q < LW'(MAX_LOCK))) begin
      lockcnt_d = lockcnt_q + LW'(1);
    end

    if (grant0 || !bus.req0) begin
      starvecnt_d = '0;
    end else if (starvecnt_q < SW'(STARVE_LIMIT)) begin
      starvecnt_d = starvecnt_q + SW'(1);
    end

    if (rvalid0_d) rd0_d = bus.mem_rd;
    if (rvalid1_d) rd1_d = bus.mem_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q         <= 1'b1;
      owner_locked_q <= 1'b0;
      lockcnt_q      <= '0;
      starvecnt_q    <= '0;
      rd0_q          <= '0;
      rd1_q          <= '0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
    end else begin
      last_q         <= last_d;
      owner_locked_q <= owner_locked_d;
      lockcnt_q      <= lockcnt_d;
      starvecnt_q    <= starvecnt_d;
      rd0_q          <= rd0_d;
      rd1_q          <= rd1_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
    end
  end

  assign bus.gnt0    = grant0;
  assign bus.gnt1    = grant1;
  assign bus.rd0     = rd0_q;
  assign bus.rd1     = rd1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle grants and
// read returns, plus hand sequences for lock bound, unbounded lock and reset.
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, write on the clock edge.
  logic [31:0] dmem [0:255];
  assign bus.mem_rd = dmem[bus.mem_adr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
      dmem[16] <= 32'hDEAD_BEEF;   // 0x40
      dmem[17] <= 32'hCAFE_F00D;   // 0x44
    end else if (bus.mem_we) begin
      dmem[bus.mem_adr[9:2]] <= bus.mem_wd;
    end
  end

  typedef struct {
    logic        req0, we0;
    logic [31:0] adr0, wd0;
    logic        req1, we1;
    logic [31:0] adr1, wd1;
    logic        lock1;
    logic        e_gnt0, e_gnt1, e_we;
    logic [31:0] e_adr, e_wd;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic l1);
    bus.req0 = r0; bus.we0 = w0; bus.adr0 = a0; bus.wd0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.adr1 = a1; bus.wd1 = d1;
    bus.lock1 = l1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int found;
    n_checks = 0;
    n_fail   = 0;

    //            req0 we0  adr0          wd0            req1 we1  adr1          wd1            lk   g0   g1   we   adr           wd             rv0  rv1  rd0            rd1
    vecs[0]  = '{1'b1,1'b0,32'h0000_0040,32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0000_0040,32'h0,         1'b0,1'b0,32'h0,         32'h0};
    vecs[1]  = '{1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b0,32'h0000_0044,32'h0,         1'b0,1'b0,1'b1,1'b0,32'h0000_0044,32'h0,         1'b1,1'b0,32'hDEAD_BEEF,32'h0};
    vecs[2]  = '{1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b1,32'hDEAD_BEEF,32'hCAFE_F00D};
    vecs[3]  = '{1'b1,1'b1,32'h0000_0100,32'hA0A0_0000,1'b1,1'b1,32'h0000_0104,32'hB1B1_0001,1'b0,1'b1,1'b0,1'b1,32'h0000_0100,32'hA0A0_0000,1'b0,1'b0,32'hDEAD_BEEF,32'hCAFE_F00D};
    vecs[4]  = '{1'b1,1'b1,32'h0000_0100,32'hA0A0_0000,1'b1,1'b1,32'h0000_0104,32'hB1B1_0001,1'b0,1'b0,1'b1,1'b1,32'h0000_0104,32'hB1B1_0001,1'b0,1'b0,32'hDEAD_BEEF,32'hCAFE_F00D};
    vecs[5]  = '{1'b1,1'b1,32'h0000_0100,32'hA0A0_0000,1'b1,1'b1,32'h0000_0104,32'hB1B1_0001,1'b0,1'b1,1'b0,1'b1,32'h0000_0100,32'hA0A0_0000,1'b0,1'b0,32'hDEAD_BEEF,32'hCAFE_F00D};
    vecs[6]  = '{1'b1,1'b1,32'h0000_0100,32'hA0A0_0000,1'b1,1'b1,32'h0000_0104,32'hB1B1_0001,1'b0,1'b0,1'b1,1'b1,32'h0000_0104,32'hB1B1_0001,1'b0,1'b0,32'hDEAD_BEEF,32'hCAFE_F00D};
    vecs[7]  = '{1'b1,1'b0,32'h0000_0104,32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0000_0104,32'h0,         1'b0,1'b0,32'hDEAD_BEEF,32'hCAFE_F00D};
    vecs[8]  = '{1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b0,32'hB1B1_0001,32'hCAFE_F00D};
    vecs[9]  = '{1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b1,32'h0000_0080,32'h1234_5678,1'b0,1'b0,1'b1,1'b1,32'h0000_0080,32'h1234_5678,1'b0,1'b0,32'hB1B1_0001,32'hCAFE_F00D};
    vecs[10] = '{1'b1,1'b0,32'h0000_0080,32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0000_0080,32'h0,         1'b0,1'b0,32'hB1B1_0001,32'hCAFE_F00D};
    vecs[11] = '{1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b1,1'b0,32'h1234_5678,32'hCAFE_F00D};
    vecs[12] = '{1'b1,1'b0,32'h0000_0040,32'h0,         1'b1,1'b0,32'h0000_0080,32'h0,         1'b0,1'b0,1'b1,1'b0,32'h0000_0080,32'h0,         1'b0,1'b0,32'h1234_5678,32'hCAFE_F00D};
    vecs[13] = '{1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,1'b1,32'h1234_5678,32'h1234_5678};

    // Reset with a pending store: no write may reach memory during reset.
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_03F0, 32'h0000_0099, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_mem_we", 32'(bus.mem_we), 32'h0);
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("rst_gnt0", 32'(bus.gnt0), 32'h0);
    check("rst_gnt1", 32'(bus.gnt1), 32'h0);
    check("rst_rvalid0", 32'(bus.rvalid0), 32'h0);
    check("rst_rvalid1", 32'(bus.rvalid1), 32'h0);
    check("rst_rd0", bus.rd0, 32'h0);
    check("rst_rd1", bus.rd1, 32'h0);
    check("rst_mem_adr", bus.mem_adr, 32'h0);
    $display("reset state: gnt0=%0b gnt1=%0b rvalid0=%0b rvalid1=%0b", bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1);
    next_cycle();

    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].req0, vecs[v].we0, vecs[v].adr0, vecs[v].wd0,
            vecs[v].req1, vecs[v].we1, vecs[v].adr1, vecs[v].wd1, vecs[v].lock1);
      @(negedge clk);
      check($sformatf("v%0d_gnt0", v), 32'(bus.gnt0), 32'(vecs[v].e_gnt0));
      check($sformatf("v%0d_gnt1", v), 32'(bus.gnt1), 32'(vecs[v].e_gnt1));
      check($sformatf("v%0d_mem_we", v), 32'(bus.mem_we), 32'(vecs[v].e_we));
      check($sformatf("v%0d_mem_adr", v), bus.mem_adr, vecs[v].e_adr);
      check($sformatf("v%0d_mem_wd", v), bus.mem_wd, vecs[v].e_wd);
      check($sformatf("v%0d_rvalid0", v), 32'(bus.rvalid0), 32'(vecs[v].e_rv0));
      check($sformatf("v%0d_rvalid1", v), 32'(bus.rvalid1), 32'(vecs[v].e_rv1));
      check($sformatf("v%0d_rd0", v), bus.rd0, vecs[v].e_rd0);
      check($sformatf("v%0d_rd1", v), bus.rd1, vecs[v].e_rd1);
      $display("vec %0d: gnt0=%0b gnt1=%0b mem_we=%0b mem_adr=0x%08h rd0=0x%08h rd1=0x%08h",
               v, bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_adr, bus.rd0, bus.rd1);
      next_cycle();
    end

    // Bounded lock: port 0 wins once after every MAX_LOCK locked port 1 grants.
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("lock_pre_gnt0", 32'(bus.gnt0), 32'h1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0077, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("lock_c%0d_gnt1", c), 32'(bus.gnt1), ((c % 5) == 4) ? 32'h0 : 32'h1);
      check($sformatf("lock_c%0d_gnt0", c), 32'(bus.gnt0), ((c % 5) == 4) ? 32'h1 : 32'h0);
      $display("lock cycle %0d: gnt0=%0b gnt1=%0b", c, bus.gnt0, bus.gnt1);
      next_cycle();
    end

    // Unbounded lock while port 0 is idle, then port 0 gets in after MAX_LOCK grants.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0088, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("freelock_c%0d_gnt1", c), 32'(bus.gnt1), 32'h1);
      $display("free lock cycle %0d: gnt1=%0b", c, bus.gnt1);
      next_cycle();
    end
    bus.req0 = 1'b1;
    bus.adr0 = 32'h0000_0040;
    found = 8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.gnt0 && found == 8) found = c;
      next_cycle();
      if (found != 8) break;
    end
    check("freelock_gnt0_wait", 32'(found), 32'(MAX_LOCK));
    $display("port 0 granted after %0d locked cycles", found);
    idle();

    // Reset in the middle of a locked port 1 read burst.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1);
    @(negedge clk);
    check("rb_pre_gnt1", 32'(bus.gnt1), 32'h1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rb_in_reset_rd1", bus.rd1, 32'hCAFE_F00D);
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1);
    @(negedge clk);
    check("rb_post_rvalid1", 32'(bus.rvalid1), 32'h0);
    check("rb_post_rd1", bus.rd1, 32'h0);
    check("rb_post_gnt0", 32'(bus.gnt0), 32'h1);
    check("rb_post_gnt1", 32'(bus.gnt1), 32'h0);
    $display("after reset: gnt0=%0b gnt1=%0b rvalid1=%0b", bus.gnt0, bus.gnt1, bus.rvalid1);
    next_cycle();
    idle();
    @(negedge clk);
    check("rb_final_rvalid0", 32'(bus.rvalid0), 32'h1);
    check("rb_final_rd0", bus.rd0, 32'hDEAD_BEEF);
    check("rb_final_gnt0", 32'(bus.gnt0), 32'h0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem) between two requesters: port 0 is the CPU load/store path, port 1 is the DMA/debug loader.
- Sits between the requesters and dmem, replacing the direct CPU-to-dmem connection inside the computer top level.
- Uses round-robin arbitration with a bounded lock (burst) for port 1 and a starvation guard for port 0.
- Read data returns registered, one cycle after grant.

Parameters:
- MAX_LOCK, 4: maximum consecutive grants port 1 may hold by asserting lock1 while port 0 is requesting.
- STARVE_LIMIT, 8: consecutive cycles port 0 may request without a grant before a forced port 0 grant.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  port 0 (CPU) access request
- we0  input  1  port 0 write enable (1 = store, 0 = load)
- adr0  input  32  port 0 byte address
- wd0  input  32  port 0 write data
- gnt0  output  1  port 0 granted this cycle
- rd0  output  32  port 0 read data, registered
- rvalid0  output  1  rd0 valid (one-cycle pulse)
- req1, we1, adr1, wd1  input  1/1/32/32  port 1 equivalents
- lock1  input  1  port 1 requests to keep its grant next cycle
- gnt1, rd1, rvalid1  output  1/32/1  port 1 equivalents
- mem_we  output  1  to dmem write enable
- mem_adr  output  32  to dmem address
- mem_wd  output  32  to dmem write data
- mem_rd  input  32  from dmem combinational read data

Behaviour:
- Reset (synchronous, active-high, takes effect at the clk edge):
  - last <= 1, so port 0 wins the first contention.
  - lockcnt <= 0, starvecnt <= 0, owner_locked <= 0.
  - rd0 = rd1 = 0; rvalid0 = rvalid1 = 0.
- Grant decision is combinational in the current cycle from req0, req1, last, owner_locked, lockcnt and starvecnt. Priority order:
  1. starvecnt == STARVE_LIMIT and req0: grant port 0.
  2. owner_locked and req1 and lockcnt < MAX_LOCK: grant port 1. If req0 = 0, the lock is not bounded by MAX_LOCK.
  3. Only one request: grant it.
  4. Both requesting: grant the port != last.
  5. Neither requesting: no grant.
- At most one of gnt0/gnt1 is high in any cycle. A grant requires the matching req in the same cycle.
- Memory mux:
  - mem_adr/mem_wd/mem_we follow the granted port.
  - With no grant: mem_we = 0, mem_adr = 0, mem_wd = 0. mem_we is never high without a grant.
- Registered read return, latency 1:
  - A granted read (we = 0) in cycle N gives rdN <= mem_rd and rvalidN = 1 in cycle N+1.
  - A granted write gives no rvalid.
  - rdN holds its value until the next read to that port. rvalid is a single-cycle pulse per granted read.
- State updates on each edge (when not in reset):
  - last <= granted port, if any grant.
  - owner_locked <= gnt1 & lock1.
  - lockcnt: increments when gnt1 & lock1 & req0; clears when port 1 is not granted or lock1 = 0; saturates at MAX_LOCK.
  - When lockcnt reaches MAX_LOCK with req0 high, the lock is broken for one arbitration: port 0 is granted next, then lockcnt clears.
  - starvecnt: increments when req0 & !gnt0; clears on gnt0 or !req0; saturates at STARVE_LIMIT.
- Requesters must hold req/we/adr/wd stable until granted. Dropping req before a grant is legal and cancels the request.
- Reset asserted mid-burst: lock, counters and rvalid clear at that edge. No write occurs in the reset cycle (mem_we forced to 0 while reset = 1).
- Widths: addresses pass through unmodified, including low bits. Counters are sized to clog2(param)+1 bits.

Test Plan:
1. Reset, then req0 read adr0 = 0x40 with dmem[0x40] = 0xDEADBEEF: gnt0 = 1 same cycle; next cycle rvalid0 = 1 and rd0 = 0xDEADBEEF; rvalid1 stays 0.
2. req0 and req1 both writing, held for 4 cycles: grants alternate 0, 1, 0, 1; mem_we = 1 each cycle with the matching adr/wd.
3. req1 + lock1 held for 10 cycles with req0 high throughout, MAX_LOCK = 4: gnt1 for 4 cycles, then gnt0 for 1 cycle, then gnt1 resumes.
4. lock1 held with req0 = 0: gnt1 every cycle indefinitely; assert req0, and port 0 is granted within MAX_LOCK+1 cycles.
5. Port 1 writes 0x12345678 to 0x80, then port 0 reads 0x80: rd0 = 0x12345678 one cycle after gnt0.
6. Assert reset during a port 1 locked burst: next cycle gnt0 = gnt1 = 0 if no req, rvalid = 0, lockcnt = 0; with both requesting afterwards, port 0 wins first.
